pim_compute_engine: RTL and testbench
=====================================

PIM_COMPUTE_ENGINE -- requirements
Module: pim_compute_engine

Interface
REQ-001 Parameter: WIDTH, default types::WIDTH, element width in bits.
REQ-002 Parameter: MATRIX_SIZE, default types::MATRIX_SIZE (4), square matrix dimension N.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 matrix_A  input  N*N x WIDTH  operand A, row-major, element [i*N+k].
REQ-007 matrix_B  input  N*N x WIDTH  operand B, row-major, element [k*N+j].
REQ-008 result  output  N*N x WIDTH  product C = A x B, row-major, registered.
REQ-009 result_ready  output  1  one-cycle completion pulse, registered.
REQ-010 busy  output  1  high from the start-sampling edge until result_ready deasserts.

Function
REQ-011 States: IDLE, MAC, DONE; state register updates on rising clk edge.
REQ-012 IDLE with start=1 at edge E0: latch matrix_A/matrix_B into internal copies, clear i, j, k and accumulator, go to MAC, set busy.
REQ-013 IDLE with start=0: hold state; result retains its last value.
REQ-014 MAC: one multiply-accumulate per cycle, acc += A[i*N+k] * B[k*N+j], using latched copies only.
REQ-015 Loop order: k innermost, then j, then i; all indices unsigned, wrap 0..N-1.
REQ-016 When k==N-1: write result[i*N+j] = acc + product, clear acc, advance j (and i when j==N-1).
REQ-017 After the element i=j=N-1 is written (edge E0+N^3), go to DONE; result_ready registered high that same edge.
REQ-018 DONE: result_ready high exactly one cycle; next edge go to IDLE, result_ready=0, busy=0.
REQ-019 Latency: result_ready high exactly N^3 cycles after E0 (64 for N=4); result fully valid while result_ready=1.
REQ-020 result SHALL remain stable from DONE until the next start is accepted, so the initiator may sample it one cycle after result_ready.
REQ-021 Arithmetic: unsigned; product truncated to WIDTH bits; accumulation modulo 2^WIDTH (default build).
REQ-022 start asserted in MAC or DONE is ignored and not queued.
REQ-023 Input matrix changes after E0 do not affect the running computation.
REQ-024 Back-to-back: start high in the IDLE cycle immediately following DONE is accepted.

Reset
REQ-025 rst=1 at an edge, in any state including mid-MAC: state=IDLE, i=j=k=0, acc=0, all result elements=0, result_ready=0, busy=0.
REQ-026 rst has priority over start; start sampled with rst=1 is discarded.

Configuration
REQ-027 Macro PIM_ACC_SATURATE_EN defined: full 2*WIDTH-bit product; accumulation clamps at 2^WIDTH-1 instead of wrapping; latency unchanged.
REQ-028 Macro PIM_ACC_SATURATE_EN undefined: truncating, wrapping arithmetic per REQ-021.

Structure
REQ-029 Package types holds WIDTH, MATRIX_SIZE and the pim_eng_state_t enum (IDLE, MAC, DONE); no local redefinition.
REQ-030 Sub-module pim_mac: combinational multiply-add of (acc, a, b) honouring PIM_ACC_SATURATE_EN; the FSM, indices and registers stay in pim_compute_engine.

Verification
REQ-031 Identity: A=I, B[n]=n (0..15), start pulse -> result[n]=n, result_ready pulse exactly 64 cycles after E0, busy high 65 cycles.
REQ-032 All-ones: A=B all 1 -> every result element = 4; second back-to-back run with A all 2 -> every element = 8.
REQ-033 Overflow, WIDTH=8: A=B all 0xFF -> default every element = 0x04; with PIM_ACC_SATURATE_EN every element = 0xFF.
REQ-034 Start during MAC (cycle 10) and with modified matrix_A -> ignored; result and single result_ready unchanged versus REQ-031.
REQ-035 rst at cycle 30 of MAC -> next cycle state IDLE, result all 0, result_ready=0, busy=0; subsequent start completes correctly.
REQ-036 Hold: after DONE, 20 idle cycles with changing inputs -> result unchanged, result_ready stays 0.

Source files
------------

// File: rtl/pim_compute_engine_pkg.sv
// types: shared widths and engine state encoding for the PIM compute engine.
package types;
  localparam int WIDTH = 8;
  localparam int MATRIX_SIZE = 4;
  typedef enum logic [1:0] {IDLE, MAC, DONE} pim_eng_state_t;
endpackage

// File: rtl/pim_compute_engine_if.sv
// pim_compute_engine_if: start/operand/result bundle between initiator (master) and engine (slave).
interface pim_compute_engine_if #(
  parameter int WIDTH = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE
);
  localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
  logic start;
  logic [WIDTH-1:0] matrix_A [NN];
  logic [WIDTH-1:0] matrix_B [NN];
  logic [WIDTH-1:0] result [NN];
  logic result_ready;
  logic busy;
  modport master (output start, matrix_A, matrix_B, input result, result_ready, busy);
  modport slave (input start, matrix_A, matrix_B, output result, result_ready, busy);
endinterface

// File: rtl/pim_compute_engine_mac.sv
// pim_mac: combinational acc + a*b; wraps by default, clamps when PIM_ACC_SATURATE_EN is defined.
module pim_mac #(
  parameter int WIDTH = types::WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
`ifdef PIM_ACC_SATURATE_EN
  localparam int PW = 2 * WIDTH + 1;
  logic [PW-1:0] total;
  assign total = PW'(acc) + PW'(a) * PW'(b);
  assign sum = total > PW'({WIDTH{1'b1}}) ? {WIDTH{1'b1}} : total[WIDTH-1:0];
`else
  assign sum = acc + a * b;
`endif
endmodule

// File: rtl/pim_compute_engine.sv
// pim_compute_engine: sequential N x N matrix multiply, one MAC per cycle (k inner, j, i outer).
// Optional saturating accumulation via PIM_ACC_SATURATE_EN (see pim_mac).
module pim_compute_engine
  import types::*;
#(
  parameter int WIDTH = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE
) (
  input logic clk,
  input logic rst,
  pim_compute_engine_if.slave bus
);
  localparam int N = MATRIX_SIZE;
  localparam int NN = N * N;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int AW = NN > 1 ? $clog2(NN) : 1;
  localparam logic [IW-1:0] L = IW'(N - 1);
  pim_eng_state_t state, state_n;
  logic [WIDTH-1:0] a_q [NN];
  logic [WIDTH-1:0] b_q [NN];
  logic [WIDTH-1:0] res_q [NN];
  logic [IW-1:0] i, j, k;
  logic [WIDTH-1:0] acc, sum;
  logic [AW-1:0] ai, bi, ri;
  logic rdy, last;
  assign ai = AW'(int'(i) * N + int'(k));
  assign bi = AW'(int'(k) * N + int'(j));
  assign ri = AW'(int'(i) * N + int'(j));
  assign last = i == L && j == L && k == L;
  pim_mac #(.WIDTH(WIDTH)) u_mac (.acc(acc), .a(a_q[ai]), .b(b_q[bi]), .sum(sum));
  always_comb begin
    state_n = state == IDLE ? (bus.start ? MAC : IDLE)
            : state == MAC  ? (last ? DONE : MAC)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      rdy <= 1'b0;
      res_q <= '{default: '0};
    end else begin
      state <= state_n;
      rdy <= state == MAC && last;
      if (state == IDLE && bus.start) begin
        a_q <= bus.matrix_A;
        b_q <= bus.matrix_B;
        i <= '0;
        j <= '0;
        k <= '0;
        acc <= '0;
      end else if (state == MAC) begin
        // end of a dot product: commit the element and step to the next (i,j)
        if (k == L) begin
          res_q[ri] <= sum;
          acc <= '0;
          k <= '0;
          j <= j == L ? '0 : j + 1'b1;
          if (j == L) i <= i == L ? '0 : i + 1'b1;
        end else begin
          acc <= sum;
          k <= k + 1'b1;
        end
      end
    end
  end
  assign bus.result = res_q;
  assign bus.result_ready = rdy;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_pim_compute_engine.sv
// tb_pim_compute_engine: table-driven and randomized checks of the 4x4, 8-bit engine against a matmul model.
module tb_pim_compute_engine;
  localparam int N = 4;
  localparam int NN = 16;
  typedef logic [NN-1:0][7:0] mat_t;
  typedef struct {
    mat_t a;
    mat_t b;
    mat_t c;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  vec_t tbl [8];
  pim_compute_engine_if bus ();
  pim_compute_engine dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic mat_t res();
    mat_t r;
    for (int n = 0; n < NN; n++) r[n] = bus.result[n];
    return r;
  endfunction
  function automatic mat_t model(input mat_t a, input mat_t b);
    mat_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int unsigned s = 0;
        for (int k = 0; k < N; k++) s += 32'(a[i*N+k]) * 32'(b[k*N+j]);
`ifdef PIM_ACC_SATURATE_EN
        r[i*N+j] = s > 255 ? 8'hFF : 8'(s);
`else
        r[i*N+j] = 8'(s % 256);
`endif
      end
    return r;
  endfunction
  function automatic mat_t rnd();
    mat_t m;
    for (int n = 0; n < NN; n++) m[n] = 8'($urandom);
    return m;
  endfunction
  task automatic drive(input mat_t a, input mat_t b);
    for (int n = 0; n < NN; n++) begin
      bus.matrix_A[n] = a[n];
      bus.matrix_B[n] = b[n];
    end
  endtask
  // Called at a negedge; start is raised immediately so consecutive calls are back-to-back.
  task automatic run(input vec_t v, input bit inject, input int id);
    int n = 0;
    int bc = 0;
    drive(v.a, v.b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bc += int'(bus.busy);
    while (!bus.result_ready && n < 200) begin
      @(negedge clk);
      n++;
      bc += int'(bus.busy);
      if (inject && n == 10) begin
        bus.start = 1'b1;
        for (int e = 0; e < NN; e++) bus.matrix_A[e] = 8'($urandom);
      end else bus.start = 1'b0;
    end
    chk($sformatf("latency[%0d]", id), 128'(n), 128'(64));
    chk($sformatf("result[%0d]", id), res(), v.c);
    @(negedge clk);
    chk($sformatf("ready_pulse[%0d]", id), 128'(bus.result_ready), 128'(0));
    chk($sformatf("busy_end[%0d]", id), 128'(bus.busy), 128'(0));
    chk($sformatf("busy_cycles[%0d]", id), 128'(bc), 128'(65));
  endtask
  initial begin
    mat_t held;
    for (int n = 0; n < NN; n++) begin
      tbl[0].a[n] = (n / N == n % N) ? 8'd1 : 8'd0;
      tbl[0].b[n] = 8'(n);
      tbl[0].c[n] = 8'(n);
      tbl[1].a[n] = 8'd1;
      tbl[1].b[n] = 8'd1;
      tbl[1].c[n] = 8'd4;
      tbl[2].a[n] = 8'd2;
      tbl[2].b[n] = 8'd1;
      tbl[2].c[n] = 8'd8;
      tbl[3].a[n] = 8'hFF;
      tbl[3].b[n] = 8'hFF;
`ifdef PIM_ACC_SATURATE_EN
      tbl[3].c[n] = 8'hFF;
`else
      tbl[3].c[n] = 8'h04;
`endif
    end
    for (int v = 4; v < 8; v++) begin
      tbl[v].a = rnd();
      tbl[v].b = rnd();
      tbl[v].c = model(tbl[v].a, tbl[v].b);
    end
    drive(tbl[1].a, tbl[1].b);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_result", res(), '0);
    chk("reset_ready", 128'(bus.result_ready), 128'(0));
    chk("reset_busy", 128'(bus.busy), 128'(0));
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_under_rst_dropped", 128'(bus.busy), 128'(0));
    for (int v = 0; v < 8; v++) run(tbl[v], 1'b0, v);
    held = res();
    for (int c = 0; c < 20; c++) begin
      drive(rnd(), rnd());
      @(negedge clk);
      chk($sformatf("hold_result[%0d]", c), res(), held);
      chk($sformatf("hold_ready[%0d]", c), 128'(bus.result_ready), 128'(0));
    end
    run(tbl[0], 1'b1, 100);
    drive(tbl[4].a, tbl[4].b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    chk("midrst_ready", 128'(bus.result_ready), 128'(0));
    chk("midrst_result", res(), '0);
    run(tbl[5], 1'b0, 200);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
